// File: rtl/ow_slave_phy_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ow_slave_phy_if : pad and engine-side signals of the 1-Wire slave PHY
// rev 1.0
// ----------------------------------------------------------------------------
interface ow_slave_phy_if;
  logic i_ena;
  logic i_ow;
  logic o_ow_oe;
  logic i_tx_en;
  logic i_tx_bit;
  logic o_tx_ack;
  logic o_rx_valid;
  logic o_rx_bit;
  logic o_reset_det;

  modport slave (
    input  i_ena, i_ow, i_tx_en, i_tx_bit,
    output o_ow_oe, o_tx_ack, o_rx_valid, o_rx_bit, o_reset_det
  );

  modport master (
    output i_ena, i_ow, i_tx_en, i_tx_bit,
    input  o_ow_oe, o_tx_ack, o_rx_valid, o_rx_bit, o_reset_det
  );
endinterface
`default_nettype wire

// File: rtl/ow_slave_phy.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ow_slave_phy : bit-level 1-Wire slave (reset/presence, write and read slots)
// rev 1.0
// ----------------------------------------------------------------------------
module ow_slave_phy #(
  parameter int CLK_PCLR  = 9,
  parameter int T_SAMPLE  = 30,
  parameter int T_HOLD    = 30,
  parameter int T_RESET   = 400,
  parameter int T_PD_WAIT = 30,
  parameter int T_PD_LOW  = 120
) (
  input wire            i_clk,
  input wire            i_rst,
  ow_slave_phy_if.slave bus
);
  localparam int            PW        = (CLK_PCLR > 0) ? $clog2(CLK_PCLR + 1) : 1;
  localparam logic [PW-1:0] c_PCLR    = PW'(CLK_PCLR);
  localparam logic [PW-1:0] c_PONE    = PW'(1);
  localparam logic [9:0]    c_SAMPLE  = 10'(T_SAMPLE);
  localparam logic [9:0]    c_HOLD    = 10'(T_HOLD);
  localparam logic [9:0]    c_RESET   = 10'(T_RESET);
  localparam logic [9:0]    c_PD_WAIT = 10'(T_PD_WAIT);
  localparam logic [9:0]    c_PD_LOW  = 10'(T_PD_LOW);
  localparam logic [9:0]    c_US_MAX  = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SLOT    = 3'd1,
    S_RST_LOW = 3'd2,
    S_PD_WAIT = 3'd3,
    S_PD_LOW  = 3'd4,
    S_PD_REC  = 3'd5
  } state_t;

  state_t        r_state, w_nxt;
  logic [1:0]    r_sync;
  logic          r_ow_d;
  logic [PW-1:0] r_pre;
  logic [9:0]    r_us;
  logic          r_mode_rd, r_tx_bit, r_pend;
  logic          r_oe, r_rx_valid, r_tx_ack, r_reset_det, r_rx_bit;
  logic          w_ow_s, w_fall, w_rise, w_enter, w_tick;
  logic          w_oe, w_rx_valid, w_tx_ack, w_reset_det, w_rx_bit, w_pend, w_latch;

  assign w_ow_s  = r_sync[1];
  assign w_fall  = r_ow_d & ~w_ow_s;
  assign w_rise  = ~r_ow_d & w_ow_s;
  assign w_tick  = (r_pre == c_PCLR);
  assign w_enter = (w_nxt != r_state);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_oe        = 1'b0;
    w_rx_valid  = 1'b0;
    w_tx_ack    = 1'b0;
    w_reset_det = 1'b0;
    w_rx_bit    = r_rx_bit;
    w_pend      = r_pend;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_latch = 1'b1;
          w_nxt   = S_SLOT;
        end
      end
      S_SLOT: begin
        if (!r_mode_rd) begin
          if (r_us == c_SAMPLE) w_pend = w_ow_s;
          // A line already high at the sample point closes the slot as a '1'
          if (w_ow_s && (r_us >= c_SAMPLE)) begin
            w_rx_bit   = (r_us == c_SAMPLE) ? w_ow_s : r_pend;
            w_rx_valid = 1'b1;
            w_nxt      = S_IDLE;
          end
        end else begin
          w_oe = ~r_tx_bit && (r_us < c_HOLD);
          if (w_ow_s && (r_us >= c_HOLD)) begin
            w_tx_ack = 1'b1;
            w_nxt    = S_IDLE;
          end
        end
        if (!w_ow_s && (r_us == c_RESET)) w_nxt = S_RST_LOW;
      end
      S_RST_LOW: begin
        if (w_rise) begin
          w_reset_det = 1'b1;
          w_nxt       = S_PD_WAIT;
        end
      end
      S_PD_WAIT: begin
        if (r_us == c_PD_WAIT) w_nxt = S_PD_LOW;
      end
      S_PD_LOW: begin
        w_oe = 1'b1;
        if (r_us == c_PD_LOW) begin
          w_oe  = 1'b0;
          w_nxt = S_PD_REC;
        end
      end
      S_PD_REC: begin
        if (w_ow_s) w_nxt = S_IDLE;
        else if (r_us == c_RESET) w_nxt = S_RST_LOW;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (!bus.i_ena) begin
      w_nxt       = S_IDLE;
      w_oe        = 1'b0;
      w_rx_valid  = 1'b0;
      w_tx_ack    = 1'b0;
      w_reset_det = 1'b0;
      w_rx_bit    = r_rx_bit;
      w_latch     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 2'b11;
      r_ow_d      <= 1'b1;
      r_pre       <= '0;
      r_us        <= '0;
      r_mode_rd   <= 1'b0;
      r_tx_bit    <= 1'b1;
      r_pend      <= 1'b1;
      r_oe        <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_reset_det <= 1'b0;
      r_rx_bit    <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], bus.i_ow};
      r_ow_d      <= w_ow_s;
      // Every state entry restarts the time base so all delays count from that event
      if (w_enter) begin
        r_pre <= '0;
        r_us  <= '0;
      end else begin
        r_pre <= w_tick ? '0 : (r_pre + c_PONE);
        if (w_tick && (r_us != c_US_MAX)) r_us <= r_us + 10'd1;
      end
      if (w_latch) begin
        r_mode_rd <= bus.i_tx_en;
        r_tx_bit  <= bus.i_tx_bit;
      end
      r_pend      <= w_pend;
      r_oe        <= w_oe;
      r_rx_valid  <= w_rx_valid;
      r_tx_ack    <= w_tx_ack;
      r_reset_det <= w_reset_det;
      r_rx_bit    <= w_rx_bit;
    end
  end

  assign bus.o_ow_oe     = r_oe;
  assign bus.o_rx_valid  = r_rx_valid;
  assign bus.o_tx_ack    = r_tx_ack;
  assign bus.o_reset_det = r_reset_det;
  assign bus.o_rx_bit    = r_rx_bit;
endmodule
`default_nettype wire

// File: doc/ow_slave_phy.md
# ow_slave_phy

Synthesizable bit-level 1-Wire slave (responder) for the Avalon 1-Wire master. It watches one open-drain 1-Wire line and detects reset pulses, which it answers with a presence pulse. It decodes master write slots into received bits and answers master read slots by holding the line low for a '0'. It sits between the bus pad and a byte/ROM-level slave engine, and the master's bus-level regression uses it as the synthesizable slave.

## Interface
- CLK_PCLR, 9 — prescaler terminal count; 1 µs tick every CLK_PCLR+1 clocks (9 = 10 MHz)
- T_SAMPLE, 30 — µs after falling edge at which a write slot is sampled
- T_HOLD, 30 — µs the slave holds the line low when answering '0' in a read slot
- T_RESET, 400 — minimum low time, in µs, classified as a reset pulse
- T_PD_WAIT, 30 — µs from the reset-pulse rising edge to the start of presence
- T_PD_LOW, 120 — presence pulse length in µs

- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ena  in  1  slave enable; 0 = invisible on bus (never pulls low, no pulses)
- ow_i  in  1  1-Wire line level from pad (asynchronous)
- ow_oe  out  1  1 = pull line low (open-drain enable)
- tx_en  in  1  1 = next slot is a read slot answered with tx_bit
- tx_bit  in  1  bit returned in a read slot
- tx_ack  out  1  1-cycle pulse: read slot finished, tx_bit consumed
- rx_valid  out  1  1-cycle pulse: write slot decoded
- rx_bit  out  1  decoded write bit; valid with rx_valid, held until next rx_valid
- reset_det  out  1  1-cycle pulse: reset pulse detected (line released)

## Operation
- ow_i goes through a 2-FF synchronizer (reset value 1) to give ow_s. A falling edge is ow_s 1→0, and a rising edge is 0→1, both relative to a registered copy.
- µs counter: 10 bits, saturates at 1023. The prescaler and µs counter clear on every state entry, so all times are measured from the entering event.
- States:
  - IDLE:
    - ow_oe=0.
    - On falling edge: latch tx_en/tx_bit and go to SLOT.
    - If the latched mode is read and the bit is 0, assert ow_oe.
  - SLOT, write mode:
    - At µs == T_SAMPLE, sample ow_s into a pending bit.
    - On rising edge with µs ≥ T_SAMPLE: rx_bit ← pending, pulse rx_valid, go to IDLE.
    - A rising edge before T_SAMPLE does not end the slot; the sample at T_SAMPLE then reads 1.
  - SLOT, read mode:
    - Drop ow_oe at µs == T_HOLD.
    - On ow_s high with µs ≥ T_HOLD: pulse tx_ack, go to IDLE.
  - SLOT, either mode, line still low at µs == T_RESET: go to RST_LOW.
    - A pending write bit is discarded: no rx_valid, no tx_ack.
  - RST_LOW: on rising edge, pulse reset_det and go to PD_WAIT.
  - PD_WAIT: at µs == T_PD_WAIT, go to PD_LOW and assert ow_oe.
  - PD_LOW: at µs == T_PD_LOW, drop ow_oe and go to PD_REC.
  - PD_REC: when ow_s is high, go to IDLE.
    - A falling edge seen here is not a slot.
    - If the line stays low T_RESET µs, go to RST_LOW.
- Falling edges during SLOT (after the initial one) are ignored.
- ena=0 (any state): next cycle state=IDLE, ow_oe=0, all pulses suppressed, in-flight operation aborted. While ena=0 the synchronizer keeps running.
- Pulse outputs are mutually exclusive and never wider than one cycle.

## Timing
- Reset values: ow_oe=0, tx_ack=0, rx_valid=0, rx_bit=0, reset_det=0, state=IDLE, sync FFs=1.
- An edge on ow_i is registered as an edge 3 clocks later (2 sync + 1 detect).
- In a read '0' slot, ow_oe rises on the clock after the falling edge is detected. That is 4 clocks after ow_i falls: 400 ns at 10 MHz, well before the master's 13 µs sample.
- rx_valid and tx_ack are issued on the clock after the qualifying rising-edge detection.
- reset_det is issued on the clock after the reset-pulse rising edge is detected.
- Presence: ow_oe is high from (T_PD_WAIT·(CLK_PCLR+1)) to ((T_PD_WAIT+T_PD_LOW)·(CLK_PCLR+1)) clocks after reset_det, ±1 clock.
- reset asserted mid-operation (e.g. in PD_LOW): all outputs return to reset values on the next clock edge.

## Test plan
Bench is at 10 MHz with default parameters, master model with 480/480 µs reset, 60 µs slots, write low 10 µs for '1' and 60 µs for '0', read low 10 µs with sample at 13 µs.
- Reset, ena=1: 480 µs low. Required: exactly one reset_det; ow_oe high 30–150 µs after release; master sample at 100 µs reads 0; no rx_valid.
- Reset, ena=0: 480 µs low. Required: no reset_det, ow_oe stays 0, master presence = 0.
- Write slots, tx_en=0: sequence 0,1,1,0 (low 60/10/10/60 µs). Required: four rx_valid pulses with rx_bit 0,1,1,0; ow_oe stays 0 throughout.
- Read slots: tx_en=1, tx_bit 0 then 1. Required:
  - Slot 1: ow_oe high from 0.4 µs to 30 µs after the fall; master reads 0.
  - Slot 2: ow_oe never high; master reads 1.
  - One tx_ack per slot, no rx_valid.
- Reset during slot: write slot held low 500 µs. Required: no rx_valid, reset_det on release, then a normal presence pulse.
- Abort: ena→0 and, in a separate run, reset→1, each 50 µs into PD_LOW. Required: ow_oe=0 on the next clock; no further pulses until the next falling edge after the block is re-enabled.
